mem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory bus between the IF fetch master and the LSU (load/store) master.
- Sequences each bus transaction through request, grant and response phases, and routes each response back to the master that owns it.
- Generates stall requests that feed the pipeline hold/flush controller.
- Honours the pipeline flush from branch-prediction failure by discarding in-flight fetch responses.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 41 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: encodings shared by the instruction/data bus arbiter.
//   state_e  : bus transaction phase (IDLE -> REQ -> RESP)
//   owner_e  : which master owns the outstanding transaction
//   GNT_IF/GNT_LS : bit positions in the selector's grant vector
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int GNT_IF           = 0;
  localparam int GNT_LS           = 1;
endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: LSU-priority selector with an IF anti-starvation counter.
//   clk, rstn    : clock, synchronous active-low reset
//   en_i         : a grant may be issued this cycle (bus idle, out of reset)
//   if_req_i     : fetch request
//   if_block_i   : fetch may not be granted this cycle (flush)
//   ls_req_i     : LSU request
//   gnt_o        : one-hot grant vector, bit GNT_IF / GNT_LS
module mem_arb_sel
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en_i,
  input  logic       if_req_i,
  input  logic       if_block_i,
  input  logic       ls_req_i,
  output logic [1:0] gnt_o
);
  logic [3:0] starve_q, starve_d;
  logic       if_due;

  always_comb begin
    if_due = (starve_q == 4'(STARVE_LIMIT));
    gnt_o  = '0;
    if (en_i) begin
      // IF wins only when LSU is quiet or IF has waited out its quota.
      if (if_req_i && !if_block_i && (!ls_req_i || if_due)) gnt_o[GNT_IF] = 1'b1;
      else if (ls_req_i)                                     gnt_o[GNT_LS] = 1'b1;
    end
    starve_d = starve_q;
    if (!if_req_i || gnt_o[GNT_IF])  starve_d = '0;
    else if (gnt_o[GNT_LS] && !if_due) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) starve_q <= '0;
    else       starve_q <= starve_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between IF fetch and LSU.
// One transaction outstanding at a time: IDLE (grant) -> REQ (hold bus
// request until mem_gnt_i) -> RESP (wait mem_rvalid_i, route to owner).
//   clk, rstn        : clock, synchronous active-low reset
//   flush_i          : prediction-fail flush, cancels the in-flight fetch
//   if_*             : fetch master (req/addr in, gnt/rvalid/rdata out)
//   ls_*             : LSU master (req/we/be/addr/wdata in, gnt/rvalid/rdata out)
//   mem_*            : memory bus (req/we/be/addr/wdata out, gnt/rvalid/rdata in)
//   if_stall_o, ls_stall_o : hold requests to the pipeline controller
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [DW/8-1:0] ls_be_i,
  input  logic [AW-1:0]   ls_addr_i,
  input  logic [DW-1:0]   ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [DW-1:0]   ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            if_stall_o,
  output logic            ls_stall_o
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [1:0]        gnt;
  logic              resp, in_req, busy_if, busy_ls;

  mem_arb_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk        (clk),
    .rstn       (rstn),
    .en_i       ((state_q == ST_IDLE) && rstn),
    .if_req_i   (if_req_i),
    .if_block_i (flush_i),
    .ls_req_i   (ls_req_i),
    .gnt_o      (gnt)
  );

  assign resp    = (state_q == ST_RESP) && mem_rvalid_i;
  assign in_req  = (state_q == ST_REQ);
  assign busy_if = (state_q != ST_IDLE) && (owner_q == OWN_IF);
  assign busy_ls = (state_q != ST_IDLE) && (owner_q == OWN_LS);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d = ST_REQ;
          if (gnt[GNT_LS]) begin
            owner_d = OWN_LS;
            we_d    = ls_we_i;
            be_d    = ls_be_i;
            addr_d  = ls_addr_i;
            wdata_d = ls_wdata_i;
          end else begin
            // Fetches are full-width reads.
            owner_d = OWN_IF;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ST_REQ:  if (mem_gnt_i)    state_d = ST_RESP;
      ST_RESP: if (mem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The bus request is never retracted; a flushed fetch is simply
    // completed on the bus and its data swallowed.
    if (flush_i && busy_if) drop_d = 1'b1;
    if (resp)               drop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign if_gnt_o    = gnt[GNT_IF];
  assign ls_gnt_o    = gnt[GNT_LS];
  assign if_rvalid_o = resp && (owner_q == OWN_IF) && !drop_q;
  assign ls_rvalid_o = resp && (owner_q == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

  assign mem_req_o   = in_req;
  assign mem_we_o    = in_req ? we_q    : 1'b0;
  assign mem_be_o    = in_req ? be_q    : '0;
  assign mem_addr_o  = in_req ? addr_q  : '0;
  assign mem_wdata_o = in_req ? wdata_q : '0;

  assign if_stall_o = (if_req_i && !if_gnt_o) || (busy_if && !if_rvalid_o && !drop_q);
  assign ls_stall_o = (ls_req_i && !ls_gnt_o) || (busy_ls && !ls_rvalid_o);
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rstn, flush, if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]  ls_be;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, if_stall, ls_stall;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  // Reference: at most one pending transaction, described by its owner,
  // whether memory has accepted it, and whether a flush has cancelled it.
  bit          m_busy, m_sent, m_ls, m_drop, m_we;
  int          m_starve;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;

  // Samples of the last cycle, for directed checks.
  logic        s_if_gnt, s_ls_gnt, s_mem_req, s_mem_we, s_if_rv, s_ls_rv, s_if_st, s_ls_st;
  logic [3:0]  s_mem_be;
  logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_ls_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .if_stall_o(if_stall), .ls_stall_o(ls_stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle against the reference, then
  // advance the reference by what the coming edge does.
  task automatic cyc();
    bit igt, lgt, mreq, resp, irv, lrv, ist, lst;
    @(negedge clk);
    igt = 0; lgt = 0;
    if (rstn && !m_busy) begin
      if (if_req && !flush && (!ls_req || m_starve == LIM)) igt = 1;
      else if (ls_req) lgt = 1;
    end
    mreq = m_busy && !m_sent;
    resp = m_busy && m_sent && mem_rvalid;
    irv  = resp && !m_ls && !m_drop;
    lrv  = resp && m_ls;
    ist  = (if_req && !igt) || (m_busy && !m_ls && !irv && !m_drop);
    lst  = (ls_req && !lgt) || (m_busy && m_ls && !lrv);
    chk("if_gnt", if_gnt, igt);
    chk("ls_gnt", ls_gnt, lgt);
    chk("mem_req", mem_req, mreq);
    chk("mem_addr", mem_addr, mreq ? m_addr : 32'h0);
    chk("mem_we", mem_we, mreq ? m_we : 1'b0);
    if (!mreq || m_ls) begin
      chk("mem_be", mem_be, mreq ? m_be : 4'h0);
      chk("mem_wdata", mem_wdata, mreq ? m_wdata : 32'h0);
    end
    chk("if_rvalid", if_rvalid, irv);
    chk("ls_rvalid", ls_rvalid, lrv);
    chk("if_rdata", if_rdata, irv ? mem_rdata : 32'h0);
    chk("ls_rdata", ls_rdata, lrv ? mem_rdata : 32'h0);
    chk("if_stall", if_stall, ist);
    chk("ls_stall", ls_stall, lst);
    s_if_gnt = if_gnt; s_ls_gnt = ls_gnt; s_mem_req = mem_req; s_mem_we = mem_we;
    s_mem_be = mem_be; s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
    s_if_rv = if_rvalid; s_ls_rv = ls_rvalid; s_if_rdata = if_rdata; s_ls_rdata = ls_rdata;
    s_if_st = if_stall; s_ls_st = ls_stall;
    if (!rstn) begin
      m_busy = 0; m_sent = 0; m_ls = 0; m_drop = 0; m_starve = 0;
    end else begin
      if (!if_req || igt) m_starve = 0;
      else if (lgt && m_starve < LIM) m_starve++;
      if (m_busy && !m_ls && flush) m_drop = 1;
      if (igt || lgt) begin
        m_busy = 1; m_sent = 0; m_ls = lgt;
        m_we    = lgt ? ls_we : 1'b0;
        m_be    = ls_be;
        m_addr  = lgt ? ls_addr : if_addr;
        m_wdata = ls_wdata;
      end else if (mreq && mem_gnt) m_sent = 1;
      else if (resp) begin
        m_busy = 0; m_drop = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    flush = 0; if_req = 0; ls_req = 0; ls_we = 0; mem_gnt = 0; mem_rvalid = 0;
  endtask

  initial begin
    int gq[$];
    rstn = 0; quiet();
    if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_be = 4'hF; mem_rdata = 0;
    m_busy = 0; m_sent = 0; m_ls = 0; m_drop = 0; m_starve = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc();
    chk("rst_mem_req", s_mem_req, 0);
    chk("rst_stall", {s_if_st, s_ls_st}, 0);
    rstn = 1;
    cyc();

    // LSU load, memory immediate
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h100;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("ld_gnt", s_ls_gnt, 1);
    ls_req = 0;
    cyc();
    chk("ld_req", s_mem_req, 1);
    chk("ld_addr", s_mem_addr, 32'h100);
    chk("ld_stall", s_ls_st, 1);
    cyc();
    chk("ld_rvalid", s_ls_rv, 1);
    chk("ld_rdata", s_ls_rdata, 32'hDEADBEEF);
    quiet(); cyc();

    // IF fetch, mem_gnt delayed 3 cycles
    if_req = 1; if_addr = 32'h200;
    cyc();
    chk("if_gnt", s_if_gnt, 1);
    if_req = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dly_addr", s_mem_addr, 32'h200);
      chk("dly_stall", s_if_st, 1);
    end
    mem_gnt = 1; cyc();
    mem_gnt = 0; cyc();
    chk("dly_norv", s_if_rv, 0);
    mem_rvalid = 1; mem_rdata = 32'h55; cyc();
    chk("dly_rv", s_if_rv, 1);
    quiet(); cyc();

    // flush during IF RESP drops the response
    if_req = 1; if_addr = 32'h300; mem_gnt = 1; cyc();
    if_req = 0; cyc();
    flush = 1; cyc();
    flush = 0; mem_rvalid = 1; mem_rdata = 32'h13; cyc();
    chk("flush_drop", s_if_rv, 0);
    mem_rvalid = 0; cyc();
    if_req = 1; if_addr = 32'h304; mem_rvalid = 1; mem_rdata = 32'h93; cyc();
    if_req = 0; cyc(); cyc();
    chk("refetch_rv", s_if_rv, 1);
    chk("refetch_rdata", s_if_rdata, 32'h93);
    quiet(); cyc();

    // LSU store under flush
    ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h400; ls_wdata = 32'h0000ABCD;
    flush = 1; mem_gnt = 1; mem_rvalid = 1; cyc();
    ls_req = 0; cyc();
    chk("st_we", s_mem_we, 1);
    chk("st_be", s_mem_be, 4'b0011);
    chk("st_wdata", s_mem_wdata, 32'h0000ABCD);
    cyc();
    chk("st_ack", s_ls_rv, 1);
    quiet(); cyc();

    // Both requesting continuously: LS x LIM then IF
    if_req = 1; ls_req = 1; mem_gnt = 1; mem_rvalid = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (s_if_gnt) gq.push_back(0);
      if (s_ls_gnt) gq.push_back(1);
    end
    chk("starve_cnt", gq.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      chk($sformatf("starve_order%0d", i), gq[i], (i % 5 == 4) ? 0 : 1);
    quiet(); cyc();

    // Reset while in REQ
    ls_req = 1; ls_we = 0; ls_addr = 32'h500; cyc();
    ls_req = 0; cyc();
    chk("rq_req", s_mem_req, 1);
    rstn = 0; cyc(); cyc();
    chk("rq_mem_req", s_mem_req, 0);
    chk("rq_outs", {s_if_gnt, s_ls_gnt, s_if_rv, s_ls_rv, s_if_st, s_ls_st}, 0);
    rstn = 1; cyc();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if_req     = ($urandom % 4) != 0;
      ls_req     = ($urandom % 2) != 0;
      flush      = ($urandom % 8) == 0;
      ls_we      = ($urandom % 2) != 0;
      ls_be      = 4'($urandom);
      if_addr    = $urandom;
      ls_addr    = $urandom;
      ls_wdata   = $urandom;
      mem_gnt    = ($urandom % 2) != 0;
      mem_rvalid = ($urandom % 2) != 0;
      mem_rdata  = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
